// File: rtl/task_answer_framer.sv
// Wraps a task's payload in a frame: SYNC, TASK_ID, length (2 bytes), payload, XOR checksum.
// Payload bytes are pulled one at a time from an upstream FIFO with a one-cycle read latency.
module task_answer_framer #(
  parameter logic [7:0] TASK_ID   = 8'h03,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tanswer_ready,
  input  logic [7:0]  i_tdata,
  input  logic        i_tanswer_data_last,
  input  logic [11:0] i_packet_size_in_bytes,
  output logic        o_tmanager_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_len_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_ID, S_LEN_H, S_LEN_L,
    S_PAYLOAD, S_ADVANCE, S_SETTLE, S_CKSUM
  } state_t;

  state_t      state_q;
  logic [11:0] len_q;
  logic [11:0] cnt_q;
  logic [7:0]  cks_q;
  logic        done_q;
  logic        len_err_q;
  logic        hs;
  logic        cnt_hits_len;

  // Outputs decode straight from state so that an asynchronous reset clears them at once.
  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_tx_last  = 1'b0;
    case (state_q)
      S_SYNC:    begin o_tx_valid = 1'b1; o_tx_data = SYNC_BYTE;            end
      S_ID:      begin o_tx_valid = 1'b1; o_tx_data = TASK_ID;              end
      S_LEN_H:   begin o_tx_valid = 1'b1; o_tx_data = {4'h0, len_q[11:8]};  end
      S_LEN_L:   begin o_tx_valid = 1'b1; o_tx_data = len_q[7:0];           end
      S_PAYLOAD: begin o_tx_valid = 1'b1; o_tx_data = i_tdata;              end
      S_CKSUM:   begin o_tx_valid = 1'b1; o_tx_data = cks_q; o_tx_last = 1'b1; end
      default:   ;
    endcase
  end

  assign hs               = o_tx_valid & i_tx_ready;
  assign cnt_hits_len     = ((cnt_q + 12'd1) == len_q);
  assign o_tmanager_ready = (state_q == S_ADVANCE);
  assign o_busy           = (state_q != S_IDLE);
  assign o_frame_done     = done_q;
  assign o_len_err        = len_err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= 12'h000;
      cnt_q     <= 12'h000;
      cks_q     <= 8'h00;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (i_tanswer_ready) begin
          len_q   <= i_packet_size_in_bytes;
          cnt_q   <= 12'h000;
          cks_q   <= 8'h00;
          state_q <= S_SYNC;
        end
        // SYNC is excluded from the checksum; every later byte is folded in on acceptance.
        S_SYNC:  if (hs) state_q <= S_ID;
        S_ID:    if (hs) begin cks_q <= cks_q ^ o_tx_data; state_q <= S_LEN_H; end
        S_LEN_H: if (hs) begin cks_q <= cks_q ^ o_tx_data; state_q <= S_LEN_L; end
        S_LEN_L: if (hs) begin
          cks_q   <= cks_q ^ o_tx_data;
          state_q <= (len_q != 12'h000) ? S_PAYLOAD : S_CKSUM;
        end
        S_PAYLOAD: if (hs) begin
          cks_q     <= cks_q ^ i_tdata;
          cnt_q     <= cnt_q + 12'd1;
          len_err_q <= (i_tanswer_data_last ^ cnt_hits_len);
          state_q   <= S_ADVANCE;
        end
        S_ADVANCE: state_q <= S_SETTLE;
        S_SETTLE:  state_q <= (cnt_q < len_q) ? S_PAYLOAD : S_CKSUM;
        S_CKSUM: if (hs) begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_answer_framer.sv
// Directed bench for task_answer_framer: framed streams, stalls, length errors, async reset.
module tb_task_answer_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tans_ready;
  logic [7:0]  tdata;
  logic        tlast;
  logic [11:0] psize;
  logic        tmgr_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic        frame_done;
  logic        len_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pay [0:511];
  logic [7:0] cap [$];
  logic       capl [$];

  always #5 clk = ~clk;

  task_answer_framer #(.TASK_ID(8'h03), .SYNC_BYTE(8'hA5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tanswer_ready(tans_ready), .i_tdata(tdata),
    .i_tanswer_data_last(tlast), .i_packet_size_in_bytes(psize),
    .o_tmanager_ready(tmgr_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .o_tx_last(tx_last), .o_busy(busy),
    .o_frame_done(frame_done), .o_len_err(len_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] out_vec();
    return {tmgr_ready, tx_data, tx_valid, tx_last, busy, frame_done, len_err};
  endfunction

  // Drives one frame; lastp is the 1-based payload byte carrying i_tanswer_data_last.
  task automatic run_frame(input string nm, input int size, input int lastp, input bit stall,
                           input logic [31:0] exp_lerr_mask, input int exp_ck);
    int idx = 0, tm = 0, tm_bad = 0, stab_err = 0, lerr_cnt = 0, nlast = 0;
    logic [31:0] lerr_mask = 0;
    bit done = 0, held = 0, tog = 1;
    logic [7:0] held_data = 0;
    logic [7:0] exp [$];
    logic [7:0] x;
    cap.delete(); capl.delete();
    for (int i = 0; i < 512; i++) pay[i] = 8'((i * 7 + 1) & 8'hFF);
    if (size == 4) for (int i = 0; i < 4; i++) pay[i] = 8'(i + 1);
    @(negedge clk);
    psize = 12'(size);
    tans_ready = 1'b1;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      tx_ready = stall ? tog : 1'b1;
      tog = ~tog;
      tdata = pay[idx];
      tlast = (idx + 1 == lastp);
      #1;
      if (busy) tans_ready = 1'b0;
      if (held && tx_valid && tx_data !== held_data) stab_err++;
      held = tx_valid && !tx_ready;
      held_data = tx_data;
      if (tmgr_ready) begin
        tm++;
        idx++;
        if (tx_valid) tm_bad++;
      end
      if (tx_valid && tx_ready) begin
        cap.push_back(tx_data);
        capl.push_back(tx_last);
        if (tx_last) nlast++;
      end
      if (len_err) begin
        lerr_cnt++;
        if (cap.size() >= 5 && cap.size() - 5 < 32) lerr_mask[cap.size() - 5] = 1'b1;
      end
      if (frame_done) done = 1;
    end
    if (!done) chk({nm, ":timeout"}, 1, 0);
    exp.push_back(8'hA5);
    exp.push_back(8'h03);
    exp.push_back({4'h0, 4'(size >> 8)});
    exp.push_back(8'(size & 8'hFF));
    for (int i = 0; i < size; i++) exp.push_back(pay[i]);
    x = 8'h00;
    for (int i = 1; i < exp.size(); i++) x ^= exp[i];
    exp.push_back(x);
    chk({nm, ":nbytes"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++)
      chk($sformatf("%s:byte%0d", nm, i), cap[i], exp[i]);
    if (exp_ck >= 0 && cap.size() > 0) chk({nm, ":cksum_hand"}, cap[cap.size() - 1], exp_ck);
    if (capl.size() > 0) chk({nm, ":last_on_final"}, capl[capl.size() - 1], 1);
    chk({nm, ":last_count"}, nlast, 1);
    chk({nm, ":tmgr_pulses"}, tm, size);
    chk({nm, ":tmgr_while_valid"}, tm_bad, 0);
    chk({nm, ":stall_stable"}, stab_err, 0);
    chk({nm, ":lerr_mask"}, lerr_mask, exp_lerr_mask);
    @(negedge clk);
    #1;
    chk({nm, ":done_one_cycle"}, frame_done, 0);
    chk({nm, ":idle_after"}, busy, 0);
  endtask

  initial begin
    int tm;
    bit hit;
    rst_n = 1'b0;
    tans_ready = 1'b0;
    tdata = 8'h00;
    tlast = 1'b0;
    psize = 12'h000;
    tx_ready = 1'b1;
    #3;
    chk("reset_outputs", 32'(out_vec()), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_no_start", busy, 0);

    run_frame("f4",      4,   4, 1'b0, 32'h0, 8'h03);
    run_frame("f0",      0,   0, 1'b0, 32'h0, 8'h03);
    run_frame("f4stall", 4,   4, 1'b1, 32'h0, 8'h03);
    run_frame("f4lerr",  4,   2, 1'b0, 32'hA, 8'h03);
    run_frame("f291",    291, 291, 1'b0, 32'h0, -1);

    // Async reset in the middle of the payload.
    @(negedge clk);
    psize = 12'd4;
    tans_ready = 1'b1;
    tx_ready = 1'b1;
    tdata = 8'h55;
    tlast = 1'b0;
    tm = 0;
    hit = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      #1;
      if (busy) tans_ready = 1'b0;
      if (tmgr_ready) tm++;
      if (tm == 2) hit = 1;
    end
    chk("rst_reach_payload", hit, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pre_valid", {busy, tx_valid, tx_data}, {1'b1, 1'b1, 8'h55});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_zero", 32'(out_vec()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tans_ready = 1'b0;
    tm = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      if (busy) tm++;
    end
    chk("rst_release_idle", tm, 0);

    run_frame("f4post", 4, 4, 1'b0, 32'h0, 8'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/task_answer_framer.md
TASK_ANSWER_FRAMER -- requirements
Module: task_answer_framer

Interface
REQ-001 SHALL have parameter TASK_ID, default 8'h03, task identifier byte placed in every frame header.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-003 SHALL have ports:
- i_clk  input  1  single clock; all logic on rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_tanswer_ready  input  1  task output stage holds a packet; i_tdata is valid while high.
- i_tdata  input  8  current payload byte from the task output stage.
- i_tanswer_data_last  input  1  task output stage flags its final byte.
- i_packet_size_in_bytes  input  12  payload length, valid while i_tanswer_ready is high.
- o_tmanager_ready  output  1  one-cycle pulse requesting the next payload byte.
- o_tx_data  output  8  framed byte stream.
- o_tx_valid  output  1  o_tx_data valid.
- i_tx_ready  input  1  sink accepts the byte when o_tx_valid and i_tx_ready are both high.
- o_tx_last  output  1  marks the checksum byte.
- o_busy  output  1  high in every state except S_IDLE.
- o_frame_done  output  1  one-cycle pulse after the checksum byte is accepted.
- o_len_err  output  1  one-cycle pulse on a payload length mismatch.

Function
REQ-004 SHALL use states S_IDLE, S_SYNC, S_ID, S_LEN_H, S_LEN_L, S_PAYLOAD, S_ADVANCE, S_SETTLE, S_CKSUM.
REQ-005 In S_IDLE with i_tanswer_ready high, SHALL latch i_packet_size_in_bytes into a 12-bit length register, clear the byte counter and checksum, and go to S_SYNC.
REQ-006 In S_SYNC, S_ID, S_LEN_H and S_LEN_L, SHALL drive SYNC_BYTE, TASK_ID, {4'h0, len[11:8]} and len[7:0] respectively with o_tx_valid high, advancing only on a handshake.
REQ-007 After S_LEN_L, SHALL enter S_PAYLOAD if len != 0, else S_CKSUM.
REQ-008 In S_PAYLOAD, SHALL drive o_tx_data = i_tdata with o_tx_valid high; on handshake, SHALL increment the counter and go to S_ADVANCE.
REQ-009 In S_ADVANCE, SHALL assert o_tmanager_ready for exactly one cycle, then go to S_SETTLE. This is the only cycle in which o_tmanager_ready is high.
REQ-010 S_SETTLE SHALL last one cycle (the upstream FIFO read latency), then go to S_PAYLOAD if counter < len, else S_CKSUM.
REQ-011 The checksum SHALL be the 8-bit XOR of every accepted byte after SYNC_BYTE (ID, both length bytes, payload). S_CKSUM SHALL drive it with o_tx_last high.
REQ-012 On S_CKSUM handshake, SHALL pulse o_frame_done for one cycle and return to S_IDLE; a new frame SHALL NOT start before the next cycle.
REQ-013 Length error: SHALL pulse o_len_err for one cycle when a payload handshake occurs with i_tanswer_data_last high while counter+1 != len, or with i_tanswer_data_last low while counter+1 == len. The frame SHALL continue to len bytes regardless.
REQ-014 While o_tx_valid is high and i_tx_ready is low, o_tx_data and o_tx_last SHALL hold stable and the state SHALL not change.
REQ-015 o_tx_valid SHALL be low in S_IDLE, S_ADVANCE and S_SETTLE. o_tx_last SHALL be high only in S_CKSUM.
REQ-016 Deassertion of i_tanswer_ready mid-frame SHALL be ignored. The frame completes using the latched len.

Reset
REQ-017 While i_rst_n is low, all outputs SHALL be 0, the state SHALL be S_IDLE, and the length, counter and checksum registers SHALL be 0. This takes effect immediately, without a clock edge, including mid-frame.
REQ-018 After i_rst_n rises, the first frame SHALL start only on i_tanswer_ready sampled high in S_IDLE.

Verification
REQ-019 Size 4, payload 01 02 03 04, i_tx_ready=1, last on byte 4: stream A5 03 00 04 01 02 03 04 03, o_tx_last on the final 03, exactly 4 o_tmanager_ready pulses, one o_frame_done, no o_len_err.
REQ-020 Size 0: stream A5 03 00 00 03, zero o_tmanager_ready pulses, o_frame_done pulses.
REQ-021 Same as REQ-019 with i_tx_ready toggling 1/0 every cycle: identical byte sequence, data stable during stalls, o_tmanager_ready never pulses while stalled.
REQ-022 Size 4, i_tanswer_data_last high on byte 2: o_len_err pulses at bytes 2 and 4, and all 9 frame bytes are still sent.
REQ-023 Size 0x123: header A5 03 01 23, 291 payload bytes, 291 o_tmanager_ready pulses, correct XOR checksum.
REQ-024 i_rst_n low during the payload: all outputs 0 asynchronously. After release with i_tanswer_ready low: o_busy stays 0.
